// File: rtl/mastermind_pkg.sv
// Shared constants, state encoding and feedback payload for the Mastermind scorer.
package mastermind_pkg;

    localparam int unsigned NUM_PEGS   = 4;
    localparam int unsigned COLOR_W    = 3;
    localparam int unsigned NUM_ROWS   = 6;
    localparam int unsigned ROW_W      = 3;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned CODE_W     = NUM_PEGS * COLOR_W;
    localparam int unsigned FEEDBACK_W = 2 * CNT_W;

    localparam logic [COLOR_W-1:0] COLOR_GRAY = COLOR_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXACT   = 2'd1,
        ST_PARTIAL = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] exact;
        logic [CNT_W-1:0] partial;
    } feedback_t;

    // Extract peg k from a packed code word.
    function automatic logic [COLOR_W-1:0] peg_at(input logic [CODE_W-1:0] code,
                                                 input logic [IDX_W-1:0]  k);
        return code[32'(k) * COLOR_W +: COLOR_W];
    endfunction

endpackage

// File: rtl/mastermind_feedback_ram.sv
// Per-row feedback register file: async reset, sync clear, one write port, comb read.
module mastermind_feedback_ram
    import mastermind_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  clear_all,
    input  logic                  we,
    input  logic [ROW_W-1:0]      wr_row,
    input  logic [FEEDBACK_W-1:0] wr_data,
    input  logic [ROW_W-1:0]      rd_row,
    output logic [FEEDBACK_W-1:0] rd_data
);

    logic [FEEDBACK_W-1:0] mem [NUM_ROWS];

    // A write to a row takes priority over a same-edge clear of that row.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (we && (wr_row == ROW_W'(r))) begin
                    mem[r] <= wr_data;
                end else if (clear_all) begin
                    mem[r] <= '0;
                end
            end
        end
    end

    // Rows outside the board read as zero.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (rd_row == ROW_W'(r)) begin
                rd_data = mem[r];
            end
        end
    end

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind feedback engine: exact pass, then multiset colour pass,
// result stored per row and a sticky win flag.
module mastermind_scorer
    import mastermind_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  start,
    input  logic [ROW_W-1:0]      row,
    input  logic [CODE_W-1:0]     guess,
    input  logic [CODE_W-1:0]     answer,
    input  logic                  clear_all,
    input  logic [ROW_W-1:0]      rd_row,
    output logic [FEEDBACK_W-1:0] rd_feedback,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      exact,
    output logic [CNT_W-1:0]      partial,
    output logic                  win
);

    state_t                state_q, state_d;
    logic [CODE_W-1:0]     g_q, g_d;
    logic [CODE_W-1:0]     a_q, a_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [NUM_PEGS-1:0]   used_g_q, used_g_d;
    logic [NUM_PEGS-1:0]   used_a_q, used_a_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      ex_cnt_q, ex_cnt_d;
    logic [CNT_W-1:0]      pa_cnt_q, pa_cnt_d;
    logic                  busy_d, done_d, win_d;
    logic [CNT_W-1:0]      exact_d, partial_d;

    logic                  we_c;
    logic                  hit_c;
    logic [COLOR_W-1:0]    g_peg_c, a_peg_c;
    feedback_t             wr_fb_c;

    assign wr_fb_c = '{exact: ex_cnt_q, partial: pa_cnt_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            g_q      <= '0;
            a_q      <= '0;
            row_q    <= '0;
            used_g_q <= '0;
            used_a_q <= '0;
            idx_q    <= '0;
            ex_cnt_q <= '0;
            pa_cnt_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            exact    <= '0;
            partial  <= '0;
            win      <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            a_q      <= a_d;
            row_q    <= row_d;
            used_g_q <= used_g_d;
            used_a_q <= used_a_d;
            idx_q    <= idx_d;
            ex_cnt_q <= ex_cnt_d;
            pa_cnt_q <= pa_cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            exact    <= exact_d;
            partial  <= partial_d;
            win      <= win_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        a_d       = a_q;
        row_d     = row_q;
        used_g_d  = used_g_q;
        used_a_d  = used_a_q;
        idx_d     = idx_q;
        ex_cnt_d  = ex_cnt_q;
        pa_cnt_d  = pa_cnt_q;
        done_d    = 1'b0;
        exact_d   = exact;
        partial_d = partial;
        win_d     = clear_all ? 1'b0 : win;
        we_c      = 1'b0;
        hit_c     = 1'b0;
        g_peg_c   = peg_at(g_q, idx_q);
        a_peg_c   = peg_at(a_q, idx_q);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    g_d      = guess;
                    a_d      = answer;
                    row_d    = row;
                    used_g_d = '0;
                    used_a_d = '0;
                    ex_cnt_d = '0;
                    pa_cnt_d = '0;
                    idx_d    = '0;
                    state_d  = ST_EXACT;
                end
            end

            ST_EXACT: begin
                if ((g_peg_c == a_peg_c) && (g_peg_c != COLOR_GRAY)) begin
                    ex_cnt_d        = ex_cnt_q + CNT_W'(1);
                    used_g_d[idx_q] = 1'b1;
                    used_a_d[idx_q] = 1'b1;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_PEGS - 1)) begin
                    state_d = ST_PARTIAL;
                end
            end

            ST_PARTIAL: begin
                // Claim the lowest unused answer peg of the same colour.
                if (!used_g_q[idx_q] && (g_peg_c != COLOR_GRAY)) begin
                    for (int k = 0; k < NUM_PEGS; k++) begin
                        if (!hit_c && !used_a_q[k] &&
                            (peg_at(a_q, IDX_W'(k)) == g_peg_c)) begin
                            hit_c       = 1'b1;
                            used_a_d[k] = 1'b1;
                        end
                    end
                end
                if (hit_c) begin
                    pa_cnt_d = pa_cnt_q + CNT_W'(1);
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_PEGS - 1)) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                we_c      = (row_q < ROW_W'(NUM_ROWS));
                exact_d   = ex_cnt_q;
                partial_d = pa_cnt_q;
                if (ex_cnt_q == CNT_W'(NUM_PEGS)) begin
                    win_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    mastermind_feedback_ram u_ram (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clear_all (clear_all),
        .we        (we_c),
        .wr_row    (row_q),
        .wr_data   (wr_fb_c),
        .rd_row    (rd_row),
        .rd_data   (rd_feedback)
    );

endmodule

// File: tb/tb_mastermind_scorer.sv
// Scoreboard bench for mastermind_scorer against a colour-count reference model.
module tb_mastermind_scorer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic [2:0]  row;
    logic [11:0] guess;
    logic [11:0] answer;
    logic        clear_all;
    logic [2:0]  rd_row;
    logic [5:0]  rd_feedback;
    logic        busy;
    logic        done;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic        win;

    mastermind_scorer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .row         (row),
        .guess       (guess),
        .answer      (answer),
        .clear_all   (clear_all),
        .rd_row      (rd_row),
        .rd_feedback (rd_feedback),
        .busy        (busy),
        .done        (done),
        .exact       (exact),
        .partial     (partial),
        .win         (win)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int     ex;
        int     pa;
        bit     w;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = 0;
    int     mtab[8];
    bit     mwin;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Reference: exact = equal non-gray positions; partial = per-colour min of leftover counts.
    function automatic void ref_score(input logic [11:0] g, input logic [11:0] a,
                                      output int ex, output int pa);
        int cg[8];
        int ca[8];
        logic [2:0] gp, ap;
        ex = 0;
        pa = 0;
        for (int c = 0; c < 8; c++) begin
            cg[c] = 0;
            ca[c] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            gp = g[3*k +: 3];
            ap = a[3*k +: 3];
            if (gp == ap && gp != 3'd0) ex++;
            else begin
                cg[gp]++;
                ca[ap]++;
            end
        end
        for (int c = 1; c < 8; c++) pa += (cg[c] < ca[c]) ? cg[c] : ca[c];
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 8; r++) mtab[r] = 0;
        mwin = 1'b0;
    endfunction

    always @(negedge Clk) begin
        if (Reset_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done=1, expected no pending scoring (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("exact",       exact,   mon_e.ex);
                check("partial",     partial, mon_e.pa);
                check("win",         win,     mon_e.w);
                check("busy_at_done", busy,   0);
                check("done_cycle",  cyc,     mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] r, input logic [11:0] g, input logic [11:0] a,
                         input bit pre_clear);
        int   ex, pa;
        exp_t e;
        @(negedge Clk);
        if (pre_clear) model_clear();
        ref_score(g, a, ex, pa);
        if (r < 3'd6) mtab[r] = ex * 8 + pa;
        if (ex == 4) mwin = 1'b1;
        e.ex  = ex;
        e.pa  = pa;
        e.w   = mwin;
        e.cyc = cyc + 10;
        sb.push_back(e);
        start  = 1'b1;
        row    = r;
        guess  = g;
        answer = a;
        @(negedge Clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 30) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected 0", n);
        end
        @(negedge Clk);
    endtask

    task automatic score(input logic [2:0] r, input logic [11:0] g, input logic [11:0] a);
        issue(r, g, a, 1'b0);
        wait_idle();
    endtask

    task automatic check_table();
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            #1;
            check($sformatf("table_row%0d", r), rd_feedback, mtab[r]);
        end
    endtask

    function automatic logic [11:0] rand_code(input int maxc);
        logic [11:0] c;
        for (int k = 0; k < 4; k++) c[3*k +: 3] = 3'($urandom_range(0, maxc));
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Reset_n   = 1'b0;
        start     = 1'b0;
        row       = '0;
        guess     = '0;
        answer    = '0;
        clear_all = 1'b0;
        rd_row    = '0;
        model_clear();
        repeat (3) @(negedge Clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_exact", exact, 0);
        check("rst_partial", partial, 0);
        check("rst_win", win, 0);
        Reset_n = 1'b1;
        check_table();

        score(3'd0, 12'o1111, 12'o1111);
        score(3'd1, 12'o4321, 12'o1234);
        score(3'd2, 12'o1211, 12'o1123);
        score(3'd3, 12'o0000, 12'o0000);
        score(3'd4, 12'o1001, 12'o1111);
        check_table();

        // Start during busy must be ignored.
        issue(3'd5, 12'o2345, 12'o5432, 1'b0);
        repeat (2) @(negedge Clk);
        start  = 1'b1;
        row    = 3'd3;
        guess  = 12'o7777;
        answer = 12'o7777;
        @(negedge Clk);
        start = 1'b0;
        wait_idle();
        check_table();

        // Off-board row: outputs update, table untouched.
        score(3'd6, 12'o1234, 12'o1243);
        check_table();

        // Clear while scoring: clear lands first, then the write is kept.
        issue(3'd5, 12'o3333, 12'o3333, 1'b1);
        @(negedge Clk);
        clear_all = 1'b1;
        @(negedge Clk);
        clear_all = 1'b0;
        wait_idle();
        check("win_after_busy_clear", win, 1);
        check_table();

        // Clear in idle.
        score(3'd0, 12'o1234, 12'o1234);
        clear_all = 1'b1;
        @(negedge Clk);
        clear_all = 1'b0;
        model_clear();
        #1;
        check("win_after_clear", win, 0);
        check_table();

        // Randomized scoring.
        for (int t = 0; t < 40; t++) begin
            score(3'($urandom_range(0, 7)),
                  rand_code((t % 2 == 0) ? 3 : 7),
                  rand_code((t % 2 == 0) ? 3 : 7));
            rd_row = 3'($urandom_range(0, 7));
            #1;
            check("rand_rd", rd_feedback, mtab[rd_row]);
        end
        check_table();

        // Reset mid-scoring after rows 0-2 are loaded.
        score(3'd0, 12'o1111, 12'o1111);
        score(3'd1, 12'o4321, 12'o1234);
        score(3'd2, 12'o1211, 12'o1123);
        issue(3'd3, 12'o5555, 12'o5555, 1'b0);
        repeat (3) @(negedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        sb.delete();
        model_clear();
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_exact", exact, 0);
        check("abort_win", win, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        check_table();
        repeat (15) @(negedge Clk);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
